// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32I fetch stage. Holds the PC, presents it to the
// asynchronous instruction memory and registers the returned word into the
// IF/ID pipeline register. Next PC is sequential or an EX redirect.
// Optional static prediction is enabled with `define FETCH_STATIC_PREDICT_EN:
// JAL and backward conditional branches are then followed at fetch time.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_dout,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_id_valid,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc,
   output logic        if_id_pred_taken,
   output logic [31:0] fetch_count
);

   localparam int          DATA_W = 32;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   // Fetch stage: program counter
   logic [DATA_W-1:0] pc_p0;
   logic [DATA_W-1:0] next_pc_p0;
   logic              pred_p0;

   // IF/ID register stage
   logic              vld_p1;
   logic [DATA_W-1:0] inst_p1;
   logic [DATA_W-1:0] pc_p1;
   logic              pred_p1;
   logic [DATA_W-1:0] fetch_count_p1;

`ifdef FETCH_STATIC_PREDICT_EN
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic signed [DATA_W-1:0] imm_p0;

   // J-type immediate, sign-extended to 32 bits
   function automatic logic signed [DATA_W-1:0] j_imm(input logic [31:0] inst);
      j_imm = $signed({{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0});
   endfunction

   // B-type immediate, sign-extended to 32 bits
   function automatic logic signed [DATA_W-1:0] b_imm(input logic [31:0] inst);
      b_imm = $signed({{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0});
   endfunction

   // Predecode the fetched word: take JAL and backward branches
   always_comb begin
      pred_p0 = 1'b0;
      imm_p0  = '0;
      if (imem_dout[6:0] == OP_JAL) begin
         pred_p0 = 1'b1;
         imm_p0  = j_imm(imem_dout);
      end else if (imem_dout[6:0] == OP_BRANCH && imem_dout[31]) begin
         pred_p0 = 1'b1;
         imm_p0  = b_imm(imem_dout);
      end
   end

   // Predicted target or fall-through, 32-bit modulo
   always_comb begin
      next_pc_p0 = pred_p0 ? pc_p0 + $unsigned(imm_p0) : pc_p0 + 32'd4;
   end
`else
   // No predictor: every fetch falls through, EX redirects all taken transfers
   always_comb begin
      pred_p0    = 1'b0;
      next_pc_p0 = pc_p0 + 32'd4;
   end
`endif

   // PC and IF/ID update: reset > redirect > stall > advance
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_p0          <= RESET_PC;
         vld_p1         <= 1'b0;
         inst_p1        <= NOP;
         pc_p1          <= '0;
         pred_p1        <= 1'b0;
         fetch_count_p1 <= '0;
      end else if (redirect_valid) begin
         // Flush to a bubble; if_id_pc keeps its last value
         pc_p0   <= {redirect_pc[31:2], 2'b00};
         vld_p1  <= 1'b0;
         inst_p1 <= NOP;
         pred_p1 <= 1'b0;
      end else if (!stall) begin
         pc_p0          <= next_pc_p0;
         vld_p1         <= 1'b1;
         inst_p1        <= imem_dout;
         pc_p1          <= pc_p0;
         pred_p1        <= pred_p0;
         fetch_count_p1 <= fetch_count_p1 + 32'd1;
      end
   end

   assign imem_addr        = pc_p0;
   assign if_id_valid      = vld_p1;
   assign if_id_inst       = inst_p1;
   assign if_id_pc         = pc_p1;
   assign if_id_pred_taken = pred_p1;
   assign fetch_count      = fetch_count_p1;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vectors for instruction_fetch with a small
// aliased instruction memory. Expectations follow FETCH_STATIC_PREDICT_EN.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_dout;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_id_valid;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc;
   logic        if_id_pred_taken;
   logic [31:0] fetch_count;

   logic [31:0] mem [0:63];
   int          n_cmp = 0;
   int          n_mis = 0;

`ifdef FETCH_STATIC_PREDICT_EN
   localparam logic [31:0] BR_NEXT   = 32'h0000_001C;
   localparam logic [31:0] BR_PRED   = 32'd1;
   localparam logic [31:0] JAL_NEXT  = 32'h0000_0018;
`else
   localparam logic [31:0] BR_NEXT   = 32'h0000_0024;
   localparam logic [31:0] BR_PRED   = 32'd0;
   localparam logic [31:0] JAL_NEXT  = 32'h0000_0014;
`endif

   instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk              (clk),
      .reset            (reset),
      .imem_addr        (imem_addr),
      .imem_dout        (imem_dout),
      .stall            (stall),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .if_id_valid      (if_id_valid),
      .if_id_inst       (if_id_inst),
      .if_id_pc         (if_id_pc),
      .if_id_pred_taken (if_id_pred_taken),
      .fetch_count      (fetch_count)
   );

   always #5 clk = ~clk;

   assign imem_dout = mem[imem_addr[7:2]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
      mem[0]  = 32'h0050_0093;
      mem[1]  = 32'h0010_0113;
      mem[4]  = 32'h0080_006F;   // JAL +8 at 0x10
      mem[8]  = 32'hFE00_0EE3;   // beq x0,x0,-4 at 0x20
      mem[16] = 32'h0000_0033;   // add at 0x40

      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      step();
      step();
      chk("rst_addr",  imem_addr, 32'h0);
      chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
      chk("rst_inst",  if_id_inst, 32'h13);
      chk("rst_pc",    if_id_pc, 32'h0);
      chk("rst_pred",  {31'd0, if_id_pred_taken}, 32'd0);
      chk("rst_cnt",   fetch_count, 32'd0);
      reset = 1'b0;

      step();
      chk("f1_pc",    if_id_pc, 32'h0);
      chk("f1_inst",  if_id_inst, 32'h0050_0093);
      chk("f1_valid", {31'd0, if_id_valid}, 32'd1);
      chk("f1_cnt",   fetch_count, 32'd1);
      chk("f1_addr",  imem_addr, 32'h4);
      step();
      chk("f2_pc",   if_id_pc, 32'h4);
      chk("f2_inst", if_id_inst, 32'h0010_0113);
      chk("f2_cnt",  fetch_count, 32'd2);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_addr", imem_addr, 32'h8);
         chk("stall_pc",   if_id_pc, 32'h4);
         chk("stall_cnt",  fetch_count, 32'd2);
      end
      stall = 1'b0;
      step();
      chk("rel_pc",   if_id_pc, 32'h8);
      chk("rel_cnt",  fetch_count, 32'd3);
      chk("rel_addr", imem_addr, 32'hC);

      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h43;
      step();
      chk("rd_addr",  imem_addr, 32'h40);
      chk("rd_valid", {31'd0, if_id_valid}, 32'd0);
      chk("rd_inst",  if_id_inst, 32'h13);
      chk("rd_pchold", if_id_pc, 32'h8);
      chk("rd_cnt",   fetch_count, 32'd3);
      stall = 1'b0; redirect_valid = 1'b0;
      step();
      chk("rd2_pc",    if_id_pc, 32'h40);
      chk("rd2_inst",  if_id_inst, 32'h0000_0033);
      chk("rd2_valid", {31'd0, if_id_valid}, 32'd1);
      chk("rd2_cnt",   fetch_count, 32'd4);

      redirect_valid = 1'b1; redirect_pc = 32'h20;
      step();
      redirect_valid = 1'b0;
      step();
      chk("br_pc",   if_id_pc, 32'h20);
      chk("br_inst", if_id_inst, 32'hFE00_0EE3);
      chk("br_next", imem_addr, BR_NEXT);
      chk("br_pred", {31'd0, if_id_pred_taken}, BR_PRED);
      chk("br_cnt",  fetch_count, 32'd5);

      redirect_valid = 1'b1; redirect_pc = 32'h10;
      step();
      redirect_valid = 1'b0;
      step();
      chk("jal_pc",   if_id_pc, 32'h10);
      chk("jal_next", imem_addr, JAL_NEXT);
      chk("jal_cnt",  fetch_count, 32'd6);

      reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
      step();
      chk("mrst_addr",  imem_addr, 32'h0);
      chk("mrst_cnt",   fetch_count, 32'd0);
      chk("mrst_valid", {31'd0, if_id_valid}, 32'd0);
      chk("mrst_pc",    if_id_pc, 32'h0);
      reset = 1'b0; redirect_valid = 1'b0;

      redirect_pc = 32'hFFFF_FFFC; redirect_valid = 1'b1;
      step();
      chk("wr_addr0", imem_addr, 32'hFFFF_FFFC);
      redirect_valid = 1'b0;
      step();
      chk("wr_addr", imem_addr, 32'h0);
      chk("wr_pc",   if_id_pc, 32'hFFFF_FFFC);
      chk("wr_cnt",  fetch_count, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the pipelined RV32I core. Holds the program counter, drives the asynchronous instruction memory address, latches the returned word into the IF/ID pipeline register, and selects the next PC. Next-PC sources are sequential, redirect from EX (branch resolution or jump), and optional static prediction. Downstream, the decode stage consumes `if_id_*`; the hazard unit and EX drive `stall` and `redirect_*`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `imem_addr` out 32: current PC to instruction memory; equals the PC register.
- `imem_dout` in 32: instruction word at `imem_addr`, combinational, same cycle.
- `stall` in 1: hold the PC and IF/ID contents.
- `redirect_valid` in 1: EX-resolved control transfer; flush and refetch.
- `redirect_pc` in 32: target PC when `redirect_valid`=1.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_inst` out 32: latched instruction; NOP 32'h0000_0013 when invalid.
- `if_id_pc` out 32: PC of `if_id_inst`.
- `if_id_pred_taken` out 1: fetch predicted this instruction taken.
- `fetch_count` out 32: number of instructions delivered to IF/ID.

## Operation
- Edge priority: reset > redirect > stall > normal advance.
- Reset: PC=`RESET_PC`, `if_id_valid`=0, `if_id_inst`=32'h13, `if_id_pc`=0, `if_id_pred_taken`=0, `fetch_count`=0.
- Normal advance (no redirect, no stall):
  - IF/ID loads {1, `imem_dout`, PC, pred}.
  - PC loads next_pc.
  - `fetch_count` increments.
- Stall without redirect: PC, IF/ID and `fetch_count` all hold.
- Redirect (with or without stall):
  - PC loads {`redirect_pc`[31:2], 2'b00}.
  - IF/ID is flushed to the reset bubble values (valid=0, inst=32'h13, pred=0); `if_id_pc` holds.
  - `fetch_count` holds.
- next_pc = pred ? PC + imm : PC + 4. Addition is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- `fetch_count` wraps from 2^32-1 to 0.
- Only PC bits [1:0] are forced to 0. Addresses beyond memory depth are passed through; the memory aliases them.

## Timing
- Fetch to IF/ID latency is 1 cycle: the word at PC in cycle n appears on `if_id_*` in cycle n+1.
- Redirect asserted in cycle n:
  - `imem_addr` = target in cycle n+1.
  - `if_id_valid`=0 in cycle n+1.
  - The target instruction is valid in cycle n+2.
- Stall is level-sensitive. Outputs are unchanged for every cycle it is high. There is no cap on stall length.
- Reset asserted mid-run: reset values apply on the next edge regardless of `stall` or `redirect_valid`.

## Configuration
- `FETCH_STATIC_PREDICT_EN` defined: `imem_dout` is predecoded combinationally.
  - JAL (opcode 7'b1101111): pred=1, imm = J-immediate.
  - B-type (opcode 7'b1100011) with inst[31]=1 (backward): pred=1, imm = B-immediate.
  - All other instructions, including JALR and forward branches: pred=0.
  - Immediates are sign-extended to 32 bits.
- Not defined: pred is always 0, next_pc = PC+4, `if_id_pred_taken` is always 0, and no predecode logic is present. EX must then redirect every taken control transfer.

## Test plan
- Reset with `RESET_PC`=0: memory words 0x00500093 and 0x00100113 at 0 and 4. Required: `if_id_pc` sequence 0, 4, 8; `if_id_inst` 0x00500093, then 0x00100113; `fetch_count` = 1, 2, 3.
- `stall`=1 for 3 cycles at PC=8. Required: `imem_addr`=8 and `if_id_pc`=4 held; `fetch_count` frozen. Resumes with `if_id_pc`=8 one cycle after release.
- `redirect_valid`=1 with `redirect_pc`=0x43 while `stall`=1. Next cycle: `imem_addr`=0x40, `if_id_valid`=0, `if_id_inst`=0x13. The following cycle: `if_id_pc`=0x40.
- With the macro defined, PC=0x20 holds 0xFE000EE3 (beq x0,x0,-4). Required: `imem_addr`=0x1C next cycle and `if_id_pred_taken`=1. Without the macro: 0x24 and 0.
- With the macro defined, JAL 0x0080006F at 0x10 yields next PC 0x18. Then reset is asserted for 1 cycle with `redirect_valid`=1. Required: PC=`RESET_PC`, `fetch_count`=0.
- PC=0xFFFF_FFFC holding a non-control word, no stall. Required: `imem_addr` wraps to 0.
